// File: rtl/pipe_ctrl_pkg.sv
// +------------------------------------------------------------------+
// | pipe_ctrl_pkg                                                    |
// | State codes and defaults shared by the pipeline control logic.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_PEND  = 2'd1,
    CTRL_FLUSH = 2'd2
  } ctrl_state_e;

  localparam int unsigned CTRL_FLUSH_CYCLES_DEF = 1;

endpackage : pipe_ctrl_pkg

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// +------------------------------------------------------------------+
// | pipe_ctrl                                                        |
// | Turns ex jump/hold requests into PC redirect, hold and flush     |
// | strobes; replays jumps captured during a bus stall.              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = CTRL_FLUSH_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  input  logic        bus_hold_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        hold_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic [1:0]  state_o
);

  localparam logic [2:0] c_CNT_INIT = (FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : 3'd0;

  ctrl_state_e r_state;
  ctrl_state_e w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic [31:0] r_pend_addr;
  logic [31:0] w_pend_nxt;
  logic        w_fire;
  logic [31:0] w_fire_addr;
  logic        w_hold;
  logic        w_flush_if;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend_addr;
    w_fire      = 1'b0;
    w_fire_addr = '0;
    w_hold      = 1'b0;
    w_flush_if  = 1'b0;

    if (bus_hold_i) begin
      // Whole pipeline frozen: counter stalls, a new jump is parked for replay.
      w_hold = 1'b1;
      if (jump_en_i && (r_state != CTRL_PEND)) begin
        w_pend_nxt  = jump_addr_i;
        w_state_nxt = CTRL_PEND;
      end
    end else begin
      unique case (r_state)
        CTRL_RUN: begin
          if (jump_en_i) begin
            w_fire      = 1'b1;
            w_fire_addr = jump_addr_i;
          end else if (hold_flag_i) begin
            w_hold = 1'b1;
          end
        end
        CTRL_PEND: begin
          w_fire      = 1'b1;
          w_fire_addr = r_pend_addr;
        end
        CTRL_FLUSH: begin
          if (jump_en_i) begin
            w_fire      = 1'b1;
            w_fire_addr = jump_addr_i;
          end else begin
            w_flush_if = 1'b1;
            if (r_cnt == 3'd0) begin
              w_state_nxt = CTRL_RUN;
            end else begin
              w_cnt_nxt = r_cnt - 3'd1;
            end
          end
        end
        default: w_state_nxt = CTRL_RUN;
      endcase

      if (w_fire) begin
        w_flush_if  = 1'b1;
        w_cnt_nxt   = c_CNT_INIT;
        w_state_nxt = (FLUSH_CYCLES > 0) ? CTRL_FLUSH : CTRL_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= CTRL_RUN;
      r_cnt       <= 3'd0;
      r_pend_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend_addr <= w_pend_nxt;
    end
  end

  assign jump_en_o     = w_fire;
  assign jump_addr_o   = w_fire_addr;
  assign hold_pc_o     = w_hold;
  assign hold_if_id_o  = w_hold;
  assign hold_id_ex_o  = w_hold;
  assign flush_if_id_o = w_flush_if;
  assign flush_id_ex_o = w_fire;
  assign state_o       = r_state;

endmodule : pipe_ctrl

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// +------------------------------------------------------------------+
// | tb_pipe_ctrl                                                     |
// | Scoreboard bench for pipe_ctrl with FLUSH_CYCLES of 0, 1 and 3.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_pipe_ctrl;

  localparam logic [1:0] c_RUN   = 2'd0;
  localparam logic [1:0] c_PEND  = 2'd1;
  localparam logic [1:0] c_FLUSH = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        hold_flag_i = 1'b0;
  logic        bus_hold_i = 1'b0;

  // Observed vector per instance: {jump_en, addr, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, state}
  logic [39:0] w_obs [3];

  typedef struct {
    int          sel;
    string       tag;
    logic [39:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned FC = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic        jen, hpc, hif, hid, fif, fid;
    logic [31:0] jad;
    logic [1:0]  st;
    pipe_ctrl #(.FLUSH_CYCLES(FC)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .jump_en_i     (jump_en_i),
      .jump_addr_i   (jump_addr_i),
      .hold_flag_i   (hold_flag_i),
      .bus_hold_i    (bus_hold_i),
      .jump_en_o     (jen),
      .jump_addr_o   (jad),
      .hold_pc_o     (hpc),
      .hold_if_id_o  (hif),
      .hold_id_ex_o  (hid),
      .flush_if_id_o (fif),
      .flush_id_ex_o (fid),
      .state_o       (st)
    );
    assign w_obs[g] = {jen, jad, hpc, hif, hid, fif, fid, st};
  end

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] ev(logic jen, logic [31:0] a, logic h, logic fif, logic fid, logic [1:0] st);
    return {jen, a, h, h, h, fif, fid, st};
  endfunction

  // Drive one cycle of stimulus and queue the outputs expected in that cycle.
  task automatic step(input int sel, input string tag, input logic j, input logic [31:0] a,
                      input logic hf, input logic bh, input logic [39:0] exp);
    sb_item_t it;
    @(posedge clk);
    #1;
    jump_en_i   = j;
    jump_addr_i = a;
    hold_flag_i = hf;
    bus_hold_i  = bh;
    it.sel = sel;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    jump_en_i = 1'b0; jump_addr_i = '0; hold_flag_i = 1'b0; bus_hold_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_item_t it;
      it = sb_q.pop_front();
      chk(it.tag, w_obs[it.sel], it.exp);
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_fc0", w_obs[0], 40'h0);
    chk("reset_fc1", w_obs[1], 40'h0);
    chk("reset_fc3", w_obs[2], 40'h0);
    rst_n = 1'b1;

    // Basic redirect, FLUSH_CYCLES=1
    step(1, "basic_jump",  1, 32'h100, 0, 0, ev(1, 32'h100, 0, 1, 1, c_RUN));
    step(1, "basic_flush", 0, 32'h0,   0, 0, ev(0, 32'h0,   0, 1, 0, c_FLUSH));
    step(1, "basic_run",   0, 32'h0,   0, 0, ev(0, 32'h0,   0, 0, 0, c_RUN));

    // Jump during bus stall
    step(1, "stall_1",    1, 32'h2000, 0, 1, ev(0, 32'h0,    1, 0, 0, c_RUN));
    step(1, "stall_2",    0, 32'h0,    0, 1, ev(0, 32'h0,    1, 0, 0, c_PEND));
    step(1, "stall_3",    0, 32'h0,    0, 1, ev(0, 32'h0,    1, 0, 0, c_PEND));
    step(1, "stall_fire", 0, 32'h0,    0, 0, ev(1, 32'h2000, 0, 1, 1, c_PEND));
    step(1, "stall_fl",   0, 32'h0,    0, 0, ev(0, 32'h0,    0, 1, 0, c_FLUSH));
    step(1, "stall_run",  0, 32'h0,    0, 0, ev(0, 32'h0,    0, 0, 0, c_RUN));

    // Ex hold for 4 cycles
    for (int i = 0; i < 4; i++)
      step(1, "ex_hold", 0, 32'h0, 1, 0, ev(0, 32'h0, 1, 0, 0, c_RUN));
    step(1, "ex_hold_end", 0, 32'h0, 0, 0, ev(0, 32'h0, 0, 0, 0, c_RUN));

    // Jump/hold collision
    step(1, "coll_jump",  1, 32'h40, 1, 0, ev(1, 32'h40, 0, 1, 1, c_RUN));
    step(1, "coll_flush", 0, 32'h0,  0, 0, ev(0, 32'h0,  0, 1, 0, c_FLUSH));
    step(1, "coll_run",   0, 32'h0,  0, 0, ev(0, 32'h0,  0, 0, 0, c_RUN));

    // Flush-counter freeze, FLUSH_CYCLES=3
    do_reset();
    step(2, "frz_jump",  1, 32'h300, 0, 0, ev(1, 32'h300, 0, 1, 1, c_RUN));
    step(2, "frz_fl1",   0, 32'h0,   0, 0, ev(0, 32'h0,   0, 1, 0, c_FLUSH));
    step(2, "frz_stall", 0, 32'h0,   0, 1, ev(0, 32'h0,   1, 0, 0, c_FLUSH));
    step(2, "frz_fl2",   0, 32'h0,   0, 0, ev(0, 32'h0,   0, 1, 0, c_FLUSH));
    step(2, "frz_fl3",   0, 32'h0,   0, 0, ev(0, 32'h0,   0, 1, 0, c_FLUSH));
    step(2, "frz_run",   0, 32'h0,   0, 0, ev(0, 32'h0,   0, 0, 0, c_RUN));

    // New jump inside FLUSH restarts the count
    do_reset();
    step(2, "rst_jump1", 1, 32'h10, 0, 0, ev(1, 32'h10, 0, 1, 1, c_RUN));
    step(2, "rst_fl1",   0, 32'h0,  0, 0, ev(0, 32'h0,  0, 1, 0, c_FLUSH));
    step(2, "rst_jump2", 1, 32'h20, 1, 0, ev(1, 32'h20, 0, 1, 1, c_FLUSH));
    for (int i = 0; i < 3; i++)
      step(2, "rst_fl", 0, 32'h0, 0, 0, ev(0, 32'h0, 0, 1, 0, c_FLUSH));
    step(2, "rst_run",   0, 32'h0,  0, 0, ev(0, 32'h0,  0, 0, 0, c_RUN));

    // FLUSH_CYCLES=0: redirect without follow-on flush
    do_reset();
    step(0, "fc0_jump", 1, 32'h80, 0, 0, ev(1, 32'h80, 0, 1, 1, c_RUN));
    step(0, "fc0_run",  0, 32'h0,  0, 0, ev(0, 32'h0,  0, 0, 0, c_RUN));

    // Reset while a jump is parked in PEND
    do_reset();
    step(2, "pend_cap",  1, 32'hDEAD0000, 0, 1, ev(0, 32'h0, 1, 0, 0, c_RUN));
    step(2, "pend_hold", 0, 32'h0,        0, 1, ev(0, 32'h0, 1, 0, 0, c_PEND));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus_hold_i = 1'b0;
    #1;
    chk("pend_rst_async", w_obs[2], 40'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      step(2, "pend_discard", 0, 32'h0, 0, 0, ev(0, 32'h0, 0, 0, 0, c_RUN));

    begin
      int budget = 100;
      while (sb_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (sb_q.size() > 0) chk("drain", 40'(sb_q.size()), 40'h0);
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pipe_ctrl

`default_nettype wire
